rate_spike_encoder: RTL

Front-end stage of the SNN datapath. Converts a frame of NUM_CH pixel intensities into per-channel rate-coded spike trains over NUM_STEPS timesteps. Each bit of spike_out drives the input_spike of one downstream LIF neuron, giving one single-cycle spike pulse per timestep. Pixels are loaded serially through a valid/ready handshake, and timesteps are paced by the global step_en tick.

---
 rtl/snn_pkg.sv | 28 ++
 rtl/lfsr16_galois.sv | 20 ++
 rtl/rate_spike_encoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN datapath: LFSR taps, per-channel seeding,
// encoder state encoding and a constant-safe clog2.
package snn_pkg;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A zero seed would lock the Galois LFSR at zero forever, so it is remapped.
  function automatic logic [15:0] ch_seed(input logic [15:0] base, input int c);
    logic [15:0] s;
    s = base ^ 16'(c * 16'h1F1F);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR with synchronous load (priority) and advance.
module lfsr16_galois
  import snn_pkg::*;
(
  input  logic        clk,
  input  logic [15:0] seed,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/rate_spike_encoder.sv
// Rate-codes a serially loaded frame of NUM_CH intensities into per-channel
// spike trains over NUM_STEPS timesteps paced by step_en.
module rate_spike_encoder
  import snn_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          PIX_WIDTH = 8,
  parameter int          NUM_STEPS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_WIDTH-1:0] pix_data,
  input  logic                 step_en,
  output logic [NUM_CH-1:0]    spike_out,
  output logic                 spike_valid,
  output logic                 busy,
  output logic                 frame_done,
  output state_t               state_dbg
);

  localparam int CH_W   = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam int STEP_W = clog2(NUM_STEPS + 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t                 state;
  logic [CH_W-1:0]        ch_idx;
  logic [STEP_W-1:0]      step_cnt;
  logic [PIX_WIDTH-1:0]   pix_buf [NUM_CH];
  logic [NUM_CH*16-1:0]   lfsr_flat;
  logic [NUM_CH-1:0]      spike_next;
  logic                   lfsr_load;
  logic                   lfsr_adv;
  logic                   unused_lfsr_bits;

  // A pixel transfers on any rising clk where pix_valid && pix_ready; pix_ready
  // depends only on state (and is held low while rst is asserted).
  assign pix_ready = (state == LOAD) && !rst;
  assign busy      = (state == RUN);
  assign state_dbg = state;

  // Reseeding on entry to RUN makes identical frames produce identical trains.
  assign lfsr_load = rst || (pix_valid && pix_ready && (ch_idx == LAST_CH));
  assign lfsr_adv  = (state == RUN) && step_en;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lfsr16_galois u_lfsr (
      .clk     (clk),
      .seed    (ch_seed(LFSR_SEED, c)),
      .load    (lfsr_load),
      .advance (lfsr_adv),
      .state   (lfsr_flat[c*16 +: 16])
    );
  end

  assign unused_lfsr_bits = ^lfsr_flat;

  always_comb begin
    spike_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      spike_next[c] = (pix_buf[c] == {PIX_WIDTH{1'b1}}) ||
                      (lfsr_flat[c*16 +: PIX_WIDTH] < pix_buf[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      ch_idx      <= '0;
      step_cnt    <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      frame_done  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) pix_buf[c] <= '0;
    end else begin
      spike_out   <= '0;
      spike_valid <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        LOAD: begin
          if (pix_valid) begin
            pix_buf[ch_idx] <= pix_data;
            if (ch_idx == LAST_CH) begin
              ch_idx   <= '0;
              step_cnt <= '0;
              state    <= RUN;
            end else begin
              ch_idx <= ch_idx + CH_W'(1);
            end
          end
        end
        RUN: begin
          if (step_en) begin
            spike_out   <= spike_next;
            spike_valid <= 1'b1;
            step_cnt    <= step_cnt + STEP_W'(1);
            if (step_cnt == LAST_STEP) begin
              frame_done <= 1'b1;
              state      <= LOAD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
